// File: rtl/prng_word_packer.sv
// prng_word_packer
// Packs the serial LFSR bit stream into WIDTH-bit words, MSB first, and
// buffers completed words in a 2-entry FIFO with a valid/ready output.
// The LFSR cannot be stalled, so a word that completes while the FIFO is
// full and not draining is dropped, flagged in a sticky overflow bit and
// counted in a saturating 8-bit drop counter.
// Optional feature macro: PRNG_PACK_ONES_EN adds a per-entry popcount
// presented on ones_out for generator bias monitoring.
module prng_word_packer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic [7:0]       drop_count
`ifdef PRNG_PACK_ONES_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] ones_out
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int OW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

`ifdef PRNG_PACK_ONES_EN
    logic [OW-1:0]    ones_mem_q [2];
    logic [OW-1:0]    ones_mem_d [2];
`endif

    logic [WIDTH-1:0] new_word;
    logic [OW-1:0]    new_ones;
    logic             complete;
    logic             do_pop;
    logic             do_push;
    logic             do_drop;

    // Word that would be completed by the bit on this edge, and the
    // handshake/push/drop decisions derived from FIFO occupancy.
    always_comb begin
        new_word = {acc_q[WIDTH-2:0], bit_in};
        complete = bit_valid && (cnt_q == CNT_LAST);
        do_pop   = (occ_q != 2'd0) && word_ready;
        do_push  = complete && ((occ_q != 2'd2) || do_pop);
        do_drop  = complete && !do_push;
    end

    // Popcount of the word being pushed; only stored when the feature is on.
    always_comb begin
        new_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_ones = new_ones + OW'(new_word[i]);
        end
    end

    // Next-state logic: flush clears everything and wins over any bit,
    // push or pop on the same edge.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
`ifdef PRNG_PACK_ONES_EN
        ones_mem_d = ones_mem_q;
`endif
        if (flush) begin
            acc_d      = '0;
            cnt_d      = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            occ_d      = 2'd0;
            overflow_d = 1'b0;
            drop_d     = 8'd0;
        end else begin
            if (bit_valid) begin
                acc_d = new_word;
                cnt_d = complete ? '0 : cnt_q + 1'b1;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = new_word;
`ifdef PRNG_PACK_ONES_EN
                ones_mem_d[wr_ptr_q] = new_ones;
`endif
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

`ifdef PRNG_PACK_ONES_EN
    // Popcount storage alongside each FIFO entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_mem_q[0] <= '0;
            ones_mem_q[1] <= '0;
        end else begin
            ones_mem_q <= ones_mem_d;
        end
    end

    assign ones_out = (occ_q != 2'd0) ? ones_mem_q[rd_ptr_q] : '0;
`endif

    // Outputs come straight from registers; head is masked to 0 when empty.
    assign word_valid = (occ_q != 2'd0);
    assign word_out   = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_prng_word_packer.sv
// Testbench for prng_word_packer (WIDTH = 8).
// A behavioural model tracks occupancy and drops; predicted words go into
// a scoreboard queue and are compared whenever the DUT hands a word over.
module tb_prng_word_packer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         bitIn;
    logic         bitValid;
    logic         flush;
    logic         wordReady;
    logic [W-1:0] wordOut;
    logic         wordValid;
    logic         overflow;
    logic [7:0]   dropCount;
`ifdef PRNG_PACK_ONES_EN
    logic [$clog2(W+1)-1:0] onesOut;
`endif

    int vecCount  = 0;
    int missCount = 0;

    logic [W-1:0] expQ [$];

    int           modelOcc;
    logic [W-1:0] modelAcc;
    int           modelCnt;
    int           modelDrops;
    logic         modelOvf;

    typedef struct {
        logic [W-1:0] word;
        int           ones;
    } vec_t;

    vec_t vecs [5];

    prng_word_packer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bitIn),
        .bit_valid  (bitValid),
        .flush      (flush),
        .word_out   (wordOut),
        .word_valid (wordValid),
        .word_ready (wordReady),
        .overflow   (overflow),
        .drop_count (dropCount)
`ifdef PRNG_PACK_ONES_EN
        ,
        .ones_out   (onesOut)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a handshake seen mid-cycle pops on the coming edge
    always @(negedge clk) begin
        if (rst && !flush && wordValid && wordReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", {24'd0, wordOut}, 32'hDEAD);
            end else begin
                logic [W-1:0] e;
                e = expQ.pop_front();
                checkOutput("word_out", {24'd0, wordOut}, {24'd0, e});
`ifdef PRNG_PACK_ONES_EN
                checkOutput("ones_out", 32'(onesOut), 32'($countones(e)));
`endif
            end
        end
    end

    task automatic modelClear();
        modelOcc   = 0;
        modelAcc   = '0;
        modelCnt   = 0;
        modelDrops = 0;
        modelOvf   = 1'b0;
        expQ.delete();
    endtask

    // One clock cycle of stimulus, with the model updated at the edge
    task automatic applyStimulus(input logic b, input logic v);
        bit pop;
        bitIn    = b;
        bitValid = v;
        flush    = 1'b0;
        pop      = (modelOcc != 0) && wordReady;
        @(posedge clk);
        if (v) begin
            modelAcc = {modelAcc[W-2:0], b};
            if (modelCnt == W - 1) begin
                modelCnt = 0;
                if (modelOcc < 2 || pop) begin
                    expQ.push_back(modelAcc);
                    modelOcc++;
                end else begin
                    modelOvf = 1'b1;
                    if (modelDrops < 255) modelDrops++;
                end
            end else begin
                modelCnt++;
            end
        end
        if (pop) modelOcc--;
        #1;
    endtask

    task automatic sendWord(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) applyStimulus(w[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        #2;
        checkOutput("rst_word_valid", 32'(wordValid), 32'd0);
        checkOutput("rst_word_out", {24'd0, wordOut}, 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop_count", {24'd0, dropCount}, 32'd0);
`ifdef PRNG_PACK_ONES_EN
        checkOutput("rst_ones_out", 32'(onesOut), 32'd0);
`endif
        modelClear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vecs[0] = '{word: 8'hB2, ones: 4};
        vecs[1] = '{word: 8'h00, ones: 0};
        vecs[2] = '{word: 8'hFF, ones: 8};
        vecs[3] = '{word: 8'h5A, ones: 4};
        vecs[4] = '{word: 8'h81, ones: 2};

        rst       = 1'b1;
        bitIn     = 1'b0;
        bitValid  = 1'b0;
        flush     = 1'b0;
        wordReady = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        doReset();

        // Table-driven packing with the consumer always ready
        wordReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sendWord(vecs[k].word);
            checkOutput("pack_valid", 32'(wordValid), 32'd1);
            checkOutput("pack_word", {24'd0, wordOut}, {24'd0, vecs[k].word});
`ifdef PRNG_PACK_ONES_EN
            checkOutput("pack_ones", 32'(onesOut), 32'(vecs[k].ones));
`endif
            idle(1);
            checkOutput("pack_valid_one_cycle", 32'(wordValid), 32'd0);
            checkOutput("pack_overflow", 32'(overflow), 32'd0);
        end

        // Backpressure: third word is dropped
        wordReady = 1'b0;
        sendWord(8'hFF);
        sendWord(8'h01);
        sendWord(8'hAA);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        checkOutput("bp_drop_count", {24'd0, dropCount}, 32'd1);
        checkOutput("bp_head", {24'd0, wordOut}, 32'hFF);
        wordReady = 1'b1;
        idle(3);
        checkOutput("bp_drained_valid", 32'(wordValid), 32'd0);
        checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

        // Push and pop on the same edge while full
        wordReady = 1'b0;
        sendWord(8'h11);
        sendWord(8'h22);
        for (int i = W - 1; i >= 1; i--) applyStimulus(1'(8'h3C >> i), 1'b1);
        wordReady = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("full_pushpop_drops", {24'd0, dropCount}, 32'(modelDrops));
        checkOutput("full_pushpop_drops_const", {24'd0, dropCount}, 32'd1);
        idle(3);
        checkOutput("full_pushpop_empty", 32'(expQ.size()), 32'd0);
        checkOutput("full_pushpop_valid", 32'(wordValid), 32'd0);

        // Gapped input, then reset mid-word
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        doReset();
        wordReady = 1'b1;
        sendWord(8'h5A);
        checkOutput("mid_rst_word", {24'd0, wordOut}, 32'h5A);
        idle(2);
        checkOutput("mid_rst_empty", 32'(expQ.size()), 32'd0);

        // Saturate the drop counter, then flush with a bit on the flush edge
        wordReady = 1'b0;
        for (int n = 0; n < 300; n++) sendWord(W'($urandom));
        checkOutput("sat_drop_count", {24'd0, dropCount}, 32'd255);
        checkOutput("sat_overflow", 32'(overflow), 32'd1);
        checkOutput("sat_valid", 32'(wordValid), 32'd1);
        flush    = 1'b1;
        bitIn    = 1'b1;
        bitValid = 1'b1;
        @(posedge clk);
        modelClear();
        #1;
        flush    = 1'b0;
        bitValid = 1'b0;
        checkOutput("flush_valid", 32'(wordValid), 32'd0);
        checkOutput("flush_drop_count", {24'd0, dropCount}, 32'd0);
        checkOutput("flush_overflow", 32'(overflow), 32'd0);
        wordReady = 1'b1;
        sendWord(8'h00);
        checkOutput("flush_next_valid", 32'(wordValid), 32'd1);
        checkOutput("flush_next_word", {24'd0, wordOut}, 32'h00);
        idle(2);
        checkOutput("final_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
